// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache-to-memory arbiter.
// Holds the FSM state encoding, the owner codes driven on the bus, and the
// byte stride between consecutive beats of a line burst.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_I_BURST = 2'b01,
    ST_D_BURST = 2'b10
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  // Bytes between consecutive beats; data path is fixed at 32-bit words.
  localparam int BEAT_STRIDE = 4;

  // Owner code presented while the FSM sits in a given state.
  function automatic logic [1:0] owner_of(input arb_state_t st);
    logic [1:0] code;
    case (st)
      ST_I_BURST: code = OWN_I;
      ST_D_BURST: code = OWN_D;
      default:    code = OWN_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache refill engines, the memory controller
// and the arbiter. The arbiter connects through the slave modport; the
// environment (caches plus memory controller) uses the master modport.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8
);
  localparam int BEAT_W = $clog2(LINE_WORDS);

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_rvalid;
  logic              ic_done;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_wready;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_rvalid;
  logic              dc_done;
  logic [BEAT_W-1:0] dc_beat;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic [1:0]        owner;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ack,
    output ic_rdata, ic_rvalid, ic_done, dc_wready, dc_rdata, dc_rvalid, dc_done,
           dc_beat, mem_req, mem_we, mem_addr, mem_wdata, owner
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ack,
    input  ic_rdata, ic_rvalid, ic_done, dc_wready, dc_rdata, dc_rvalid, dc_done,
           dc_beat, mem_req, mem_we, mem_addr, mem_wdata, owner
  );

endinterface

// File: rtl/cache_mem_arbiter_line_beat_counter.sv
// Beat index within a line burst. Cleared between bursts, advanced on each
// acknowledged beat, and never allowed past the last beat of the line.
module line_beat_counter #(
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          inc,
  output logic [$clog2(LINE_WORDS)-1:0] beat,
  output logic                          last
);
  localparam int            BW        = $clog2(LINE_WORDS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  logic [BW-1:0] beat_r;

  // Beat register: clear has priority; increment holds at the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_r <= {BW{1'b0}};
    end else if (clr) begin
      beat_r <= {BW{1'b0}};
    end else if (inc && (beat_r != LAST_BEAT)) begin
      beat_r <= beat_r + BW'(1);
    end else begin
      beat_r <= beat_r;
    end
  end

  assign beat = beat_r;
  assign last = (beat_r == LAST_BEAT);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing one main-memory port between the I-cache refill engine and
// the D-cache refill/writeback engine. Every grant is a whole line burst.
// Optional build macro CACHE_ARB_RR_EN selects round-robin arbitration on
// simultaneous requests; without it the D-side always wins a tie.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8
) (
  input logic                clk,
  input logic                rst_n,
  cache_mem_arbiter_if.slave bus
);
  localparam int                BW         = $clog2(LINE_WORDS);
  localparam int                OFF_W      = BW + $clog2(BEAT_STRIDE);
  localparam int                BEAT_SHIFT = $clog2(BEAT_STRIDE);
  localparam logic [ADDR_W-1:0] LINE_MASK  = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  arb_state_t        state_r;
  logic [1:0]        owner_r;
  logic              mem_req_r;
  logic              we_r;
  logic [ADDR_W-1:0] base_r;

  logic [BW-1:0]     beat_s;
  logic              last_s;
  logic              ack_s;
  logic              clr_s;
  logic              grant_i_s;
  logic              grant_d_s;

`ifdef CACHE_ARB_RR_EN
  // High when the D-side took the most recent grant.
  logic              last_d_r;
`endif

  // An ack only counts while a burst owns the port; finishing the last beat
  // (or idling) clears the counter so every burst starts at beat 0.
  assign ack_s = (state_r != ST_IDLE) && bus.mem_ack;
  assign clr_s = (state_r == ST_IDLE) || (ack_s && last_s);

  line_beat_counter #(
    .LINE_WORDS(LINE_WORDS)
  ) u_beat (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_s),
    .inc  (ack_s),
    .beat (beat_s),
    .last (last_s)
  );

  // Arbitration among pending requests; only consulted in IDLE.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (bus.dc_req && bus.ic_req) begin
`ifdef CACHE_ARB_RR_EN
      if (last_d_r) begin
        grant_i_s = 1'b1;
      end else begin
        grant_d_s = 1'b1;
      end
`else
      grant_d_s = 1'b1;
`endif
    end else if (bus.dc_req) begin
      grant_d_s = 1'b1;
    end else if (bus.ic_req) begin
      grant_i_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Burst FSM: grants a line, latches its base and direction, and releases the
  // port on the acknowledged last beat. Requests are not sampled mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      owner_r   <= OWN_NONE;
      mem_req_r <= 1'b0;
      we_r      <= 1'b0;
      base_r    <= {ADDR_W{1'b0}};
`ifdef CACHE_ARB_RR_EN
      last_d_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_d_s) begin
            state_r   <= ST_D_BURST;
            owner_r   <= owner_of(ST_D_BURST);
            mem_req_r <= 1'b1;
            we_r      <= bus.dc_we;
            base_r    <= bus.dc_addr & LINE_MASK;
`ifdef CACHE_ARB_RR_EN
            last_d_r  <= 1'b1;
`endif
          end else if (grant_i_s) begin
            state_r   <= ST_I_BURST;
            owner_r   <= owner_of(ST_I_BURST);
            mem_req_r <= 1'b1;
            we_r      <= 1'b0;
            base_r    <= bus.ic_addr & LINE_MASK;
`ifdef CACHE_ARB_RR_EN
            last_d_r  <= 1'b0;
`endif
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_I_BURST, ST_D_BURST: begin
          if (ack_s && last_s) begin
            state_r   <= ST_IDLE;
            owner_r   <= owner_of(ST_IDLE);
            mem_req_r <= 1'b0;
            we_r      <= 1'b0;
          end else begin
            state_r   <= state_r;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          owner_r   <= OWN_NONE;
          mem_req_r <= 1'b0;
          we_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.owner    = owner_r;
  assign bus.mem_req  = mem_req_r;
  assign bus.mem_we   = we_r;
  assign bus.mem_addr = mem_req_r ? (base_r + (ADDR_W'(beat_s) << BEAT_SHIFT))
                                  : {ADDR_W{1'b0}};

  // Steer read data, valid, done and write handshakes to the current owner.
  always_comb begin
    bus.ic_rdata  = {DATA_W{1'b0}};
    bus.ic_rvalid = 1'b0;
    bus.ic_done   = 1'b0;
    bus.dc_rdata  = {DATA_W{1'b0}};
    bus.dc_rvalid = 1'b0;
    bus.dc_done   = 1'b0;
    bus.dc_wready = 1'b0;
    bus.dc_beat   = {BW{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    case (state_r)
      ST_I_BURST: begin
        bus.ic_rdata  = bus.mem_rdata;
        bus.ic_rvalid = bus.mem_ack;
        bus.ic_done   = bus.mem_ack && last_s;
      end
      ST_D_BURST: begin
        bus.dc_rdata  = bus.mem_rdata;
        bus.dc_rvalid = bus.mem_ack && !we_r;
        bus.dc_wready = bus.mem_ack && we_r;
        bus.dc_done   = bus.mem_ack && last_s;
        bus.dc_beat   = beat_s;
        bus.mem_wdata = we_r ? bus.dc_wdata : {DATA_W{1'b0}};
      end
      default: begin
        bus.dc_beat   = {BW{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: randomized addresses, data and
// ack patterns, with expectations derived from line/beat arithmetic.
module tb_cache_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] wseed;
  int          checks;
  int          errors;

  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(8)) bus ();

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // D-side writeback source: word for the beat index the arbiter asks for.
  assign bus.dc_wdata = wseed ^ (32'(bus.dc_beat) * 32'h0101_0101);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive acks until the given side signals done; cycles = -1 on timeout.
  task automatic finish_burst(input bit side_d, output int cycles, output logic [1:0] first_owner);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    first_owner = 2'b11;
    while (!seen && cycles < 50) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = $urandom;
      @(negedge clk);
      if (cycles == 0) first_owner = bus.owner;
      seen = side_d ? (bus.dc_done === 1'b1) : (bus.ic_done === 1'b1);
      cycles++;
      tick();
    end
    bus.mem_ack = 1'b0;
    if (!seen) cycles = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ic_req = 1'b1; bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.mem_ack = 1'b1;
    bus.ic_addr = $urandom; bus.dc_addr = $urandom; bus.mem_rdata = $urandom;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (bus.owner !== 2'b00 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 ||
        bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.dc_beat !== 3'd0) begin
      errors++;
      $display("FAIL reset_bus: owner=%b req=%b we=%b addr=%h wdata=%h beat=%0d, expected all zero",
               bus.owner, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.dc_beat);
    end
    checks++;
    if (bus.ic_rvalid !== 1'b0 || bus.dc_rvalid !== 1'b0 || bus.ic_done !== 1'b0 ||
        bus.dc_done !== 1'b0 || bus.dc_wready !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: ic_rv=%b dc_rv=%b ic_done=%b dc_done=%b wready=%b, expected 0",
               bus.ic_rvalid, bus.dc_rvalid, bus.ic_done, bus.dc_done, bus.dc_wready);
    end
    tick();
    bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.mem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.owner !== 2'b00 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: owner=%b req=%b, expected 00/0", bus.owner, bus.mem_req);
    end
    tick();
  endtask

  task automatic test_i_refill();
    logic [31:0] addr, base, rd;
    int beat, cyc;
    bit ack;
    for (int n = 0; n < 3; n++) begin
      addr = (n == 0) ? 32'h0000_1234 : $urandom;
      base = addr & 32'hFFFF_FFE0;
      bus.ic_req = 1'b1; bus.ic_addr = addr; bus.mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.owner !== 2'b00 || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL i_grant_latency: owner=%b req=%b, expected 00/0", bus.owner, bus.mem_req);
      end
      tick();
      beat = 0; cyc = 0;
      while (beat < 8 && cyc < 64) begin
        ack = (n == 0) ? 1'b1 : ($urandom_range(0, 1) != 0);
        rd  = $urandom;
        bus.mem_ack = ack; bus.mem_rdata = rd;
        @(negedge clk);
        checks++;
        if (bus.owner !== 2'b01 || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 ||
            bus.mem_addr !== base + 32'(beat * 4)) begin
          errors++;
          $display("FAIL i_addr: owner=%b req=%b we=%b addr=%h, expected 01/1/0/%h",
                   bus.owner, bus.mem_req, bus.mem_we, bus.mem_addr, base + 32'(beat * 4));
        end
        checks++;
        if (bus.ic_rvalid !== ack || (ack && bus.ic_rdata !== rd) ||
            bus.ic_done !== (ack && beat == 7) || bus.dc_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL i_data: rvalid=%b rdata=%h done=%b, expected %b/%h/%b",
                   bus.ic_rvalid, bus.ic_rdata, bus.ic_done, ack, rd, ack && beat == 7);
        end
        if (ack) beat++;
        cyc++;
        tick();
      end
      bus.ic_req = 1'b0; bus.mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.owner !== 2'b00 || bus.mem_req !== 1'b0 || beat != 8) begin
        errors++;
        $display("FAIL i_end: owner=%b req=%b beats=%0d, expected 00/0/8", bus.owner, bus.mem_req, beat);
      end
      tick();
    end
  endtask

  task automatic test_d_writeback();
    logic [31:0] addr, base;
    int beat, cyc;
    bit ack;
    for (int n = 0; n < 3; n++) begin
      addr  = (n == 0) ? 32'h0000_2000 : $urandom;
      base  = addr & 32'hFFFF_FFE0;
      wseed = $urandom;
      bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = addr; bus.mem_ack = 1'b0;
      tick();
      beat = 0; cyc = 0;
      while (beat < 8 && cyc < 64) begin
        ack = (n == 0) ? (cyc % 2 == 1) : ($urandom_range(0, 1) != 0);
        bus.mem_ack = ack; bus.mem_rdata = $urandom;
        @(negedge clk);
        checks++;
        if (bus.owner !== 2'b10 || bus.mem_we !== 1'b1 || bus.mem_addr !== base + 32'(beat * 4) ||
            bus.dc_beat !== 3'(beat)) begin
          errors++;
          $display("FAIL d_wb_addr: owner=%b we=%b addr=%h beat=%0d, expected 10/1/%h/%0d",
                   bus.owner, bus.mem_we, bus.mem_addr, bus.dc_beat, base + 32'(beat * 4), beat);
        end
        checks++;
        if (bus.mem_wdata !== (wseed ^ (32'(beat) * 32'h0101_0101)) || bus.dc_wready !== ack ||
            bus.dc_rvalid !== 1'b0 || bus.dc_done !== (ack && beat == 7)) begin
          errors++;
          $display("FAIL d_wb_data: wdata=%h wready=%b rvalid=%b done=%b, expected %h/%b/0/%b",
                   bus.mem_wdata, bus.dc_wready, bus.dc_rvalid, bus.dc_done,
                   wseed ^ (32'(beat) * 32'h0101_0101), ack, ack && beat == 7);
        end
        if (ack) beat++;
        cyc++;
        tick();
      end
      bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.owner !== 2'b00 || bus.mem_we !== 1'b0 || beat != 8 || (n == 0 && cyc != 16)) begin
        errors++;
        $display("FAIL d_wb_end: owner=%b we=%b beats=%0d cycles=%0d, expected 00/0/8/%0d",
                 bus.owner, bus.mem_we, beat, cyc, (n == 0) ? 16 : cyc);
      end
      tick();
    end
  endtask

  task automatic test_drop_req();
    logic [31:0] addr, base, rd;
    int beat, cyc, dones;
    bit ack;
    addr = $urandom; base = addr & 32'hFFFF_FFE0;
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = addr; bus.mem_ack = 1'b0;
    tick();
    beat = 0; cyc = 0; dones = 0;
    while (beat < 8 && cyc < 64) begin
      if (beat >= 3) bus.dc_req = 1'b0;
      ack = ($urandom_range(0, 3) != 0);
      rd  = $urandom;
      bus.mem_ack = ack; bus.mem_rdata = rd;
      @(negedge clk);
      checks++;
      if (bus.owner !== 2'b10 || bus.mem_we !== 1'b0 || bus.mem_addr !== base + 32'(beat * 4) ||
          bus.dc_rvalid !== ack || (ack && bus.dc_rdata !== rd) || bus.dc_wready !== 1'b0 ||
          bus.dc_done !== (ack && beat == 7)) begin
        errors++;
        $display("FAIL d_drop_beat: owner=%b addr=%h rvalid=%b rdata=%h done=%b, expected 10/%h/%b/%h/%b",
                 bus.owner, bus.mem_addr, bus.dc_rvalid, bus.dc_rdata, bus.dc_done,
                 base + 32'(beat * 4), ack, rd, ack && beat == 7);
      end
      if (bus.dc_done === 1'b1) dones++;
      if (ack) beat++;
      cyc++;
      tick();
    end
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.owner !== 2'b00 || beat != 8 || dones != 1) begin
      errors++;
      $display("FAIL d_drop_end: owner=%b beats=%0d dones=%0d, expected 00/8/1", bus.owner, beat, dones);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.owner !== 2'b00 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL d_drop_idle: owner=%b req=%b, expected 00/0", bus.owner, bus.mem_req);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    bit served_last_d, exp_d;
    int cyc;
    logic [1:0] fo;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    served_last_d = 1'b0;
    for (int r = 0; r < 2; r++) begin
`ifdef CACHE_ARB_RR_EN
      exp_d = !served_last_d;
`else
      exp_d = 1'b1;
`endif
      bus.ic_addr = $urandom; bus.dc_addr = $urandom; bus.dc_we = 1'b0;
      bus.ic_req = 1'b1; bus.dc_req = 1'b1; bus.mem_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.owner !== 2'b00 || bus.mem_req !== 1'b0 || bus.ic_rvalid !== 1'b0 || bus.dc_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL sim_idle: owner=%b req=%b rvalids=%b%b, expected idle with ack ignored",
                 bus.owner, bus.mem_req, bus.ic_rvalid, bus.dc_rvalid);
      end
      tick();
      finish_burst(exp_d, cyc, fo);
      served_last_d = exp_d;
      checks++;
      if (fo !== (exp_d ? 2'b10 : 2'b01) || cyc != 8) begin
        errors++;
        $display("FAIL sim_winner_round%0d: owner=%b cycles=%0d, expected %b/8", r, fo, cyc, exp_d ? 2'b10 : 2'b01);
      end
      if (r == 0) begin
        bus.ic_req = 1'b0; bus.dc_req = 1'b0;
      end else begin
        if (exp_d) bus.dc_req = 1'b0; else bus.ic_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.owner !== 2'b00 || bus.mem_req !== 1'b0) begin
          errors++;
          $display("FAIL sim_bubble: owner=%b req=%b, expected 00/0", bus.owner, bus.mem_req);
        end
        tick();
        finish_burst(!exp_d, cyc, fo);
        served_last_d = !exp_d;
        checks++;
        if (fo !== (exp_d ? 2'b01 : 2'b10) || cyc != 8) begin
          errors++;
          $display("FAIL sim_loser: owner=%b cycles=%0d, expected %b/8", fo, cyc, exp_d ? 2'b01 : 2'b10);
        end
        bus.ic_req = 1'b0; bus.dc_req = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (bus.owner !== 2'b00) begin
        errors++;
        $display("FAIL sim_end_round%0d: owner=%b, expected 00", r, bus.owner);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] addr, base;
    int dones, cyc;
    logic [1:0] fo;
    addr = $urandom; base = addr & 32'hFFFF_FFE0;
    bus.ic_req = 1'b1; bus.ic_addr = addr; bus.mem_ack = 1'b0;
    tick();
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
      @(negedge clk);
      if (bus.ic_done === 1'b1) dones++;
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.owner !== 2'b00 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 ||
        bus.ic_rvalid !== 1'b0 || bus.ic_done !== 1'b0 || dones != 0) begin
      errors++;
      $display("FAIL rst_mid: owner=%b req=%b addr=%h rvalid=%b done=%b early_dones=%0d, expected zeros",
               bus.owner, bus.mem_req, bus.mem_addr, bus.ic_rvalid, bus.ic_done, dones);
    end
    tick();
    rst_n = 1'b1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.owner !== 2'b00) begin
      errors++;
      $display("FAIL rst_idle: owner=%b, expected 00", bus.owner);
    end
    tick();
    bus.mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.owner !== 2'b01 || bus.mem_addr !== base) begin
      errors++;
      $display("FAIL rst_restart: owner=%b addr=%h, expected 01/%h", bus.owner, bus.mem_addr, base);
    end
    tick();
    finish_burst(1'b0, cyc, fo);
    checks++;
    if (cyc != 7 || fo !== 2'b01) begin
      errors++;
      $display("FAIL rst_rest: cycles=%0d owner=%b, expected 7/01", cyc, fo);
    end
    bus.ic_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr, base;
    int cyc;
    logic [1:0] fo;
    addr = $urandom; base = addr & 32'hFFFF_FFE0;
    bus.ic_req = 1'b1; bus.ic_addr = addr; bus.mem_ack = 1'b0;
    tick();
    finish_burst(1'b0, cyc, fo);
    checks++;
    if (cyc != 8 || fo !== 2'b01) begin
      errors++;
      $display("FAIL b2b_first: cycles=%0d owner=%b, expected 8/01", cyc, fo);
    end
    @(negedge clk);
    checks++;
    if (bus.owner !== 2'b00 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_bubble: owner=%b req=%b, expected 00/0", bus.owner, bus.mem_req);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.owner !== 2'b01 || bus.mem_req !== 1'b1 || bus.mem_addr !== base) begin
      errors++;
      $display("FAIL b2b_second: owner=%b req=%b addr=%h, expected 01/1/%h", bus.owner, bus.mem_req, bus.mem_addr, base);
    end
    tick();
    finish_burst(1'b0, cyc, fo);
    checks++;
    if (cyc != 8 || fo !== 2'b01) begin
      errors++;
      $display("FAIL b2b_second_len: cycles=%0d owner=%b, expected 8/01", cyc, fo);
    end
    bus.ic_req = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wseed  = 32'h0;
    bus.ic_req = 1'b0; bus.ic_addr = 32'h0;
    bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = 32'h0;
    bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_i_refill();
    test_d_writeback();
    test_drop_req();
    test_simultaneous();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single main-memory port between the instruction-cache refill engine and the data-cache refill/writeback engine. Each grant is a full cache-line burst of `LINE_WORDS` beats. The block sits between the two caches and the memory controller. While a cache waits for its grant or its burst to complete, that cache keeps its `ICacheMiss`/`DCacheMiss` asserted, which holds the whole pipeline stalled through the hazard logic.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: word width. Fixed at 32 because beat addressing uses a 4-byte stride.
- `LINE_WORDS`, default 8: beats per burst. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ic_req`  in  1  I-side burst request. Held until `ic_done`.
- `ic_addr`  in  ADDR_W  I-side line address. Low log2(LINE_WORDS)+2 bits are ignored.
- `ic_rdata`  out  DATA_W  returned beat for the I-side.
- `ic_rvalid`  out  1  `ic_rdata` is valid this cycle.
- `ic_done`  out  1  one-cycle pulse on the last beat of an I-side burst.
- `dc_req`  in  1  D-side burst request. Held until `dc_done`.
- `dc_we`  in  1  D-side burst direction: 1 = writeback, 0 = refill.
- `dc_addr`  in  ADDR_W  D-side line address, aligned the same way as `ic_addr`.
- `dc_wdata`  in  DATA_W  writeback beat for the current beat index.
- `dc_wready`  out  1  `dc_wdata` consumed this cycle; the D-side advances to the next beat.
- `dc_rdata`  out  DATA_W  returned beat for the D-side.
- `dc_rvalid`  out  1  `dc_rdata` is valid this cycle.
- `dc_done`  out  1  one-cycle pulse on the last beat of a D-side burst.
- `dc_beat`  out  log2(LINE_WORDS)  current beat index, used by the D-side to select `dc_wdata`.
- `mem_req`  out  1  memory beat request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  beat byte address.
- `mem_wdata`  out  DATA_W  write data to memory.
- `mem_rdata`  in  DATA_W  read data from memory.
- `mem_ack`  in  1  beat completes this cycle.
- `owner`  out  2  current grant: 00 none, 01 I, 10 D.

## Operation
- States:
  - IDLE: `owner`=00, `mem_req`=0.
  - I_BURST: `owner`=01.
  - D_BURST: `owner`=10.
- Transitions:
  - IDLE → D_BURST when `dc_req` is high and D wins arbitration; IDLE → I_BURST when `ic_req` is high and I wins (see Configuration).
  - On entry to either burst, latch the line base (address with the low bits cleared) and `dc_we`, and clear the beat counter.
  - In a burst state, `mem_req`=1 and `mem_addr` = base + beat·4.
  - Each `mem_ack` increments the beat counter.
  - The ack on beat `LINE_WORDS`−1 pulses `done` and returns the FSM to IDLE.
- Read path, combinational: owner `rdata` = `mem_rdata`; owner `rvalid` = `mem_ack` && !we.
- Write path, D-side only: `mem_we`=1, `mem_wdata`=`dc_wdata`, `dc_wready`=`mem_ack`.
- `req` inputs and `mem_ack` are ignored outside the states in which they are meaningful.
- A requester dropping `req` mid-burst does not abort the burst; it completes and `done` still pulses.
- A requester must deassert `req` the cycle after `done`. If `req` is still high in the following IDLE cycle, that is a new request.
- Beat counter wraps to 0 only via return to IDLE; it never exceeds `LINE_WORDS`−1.

## Timing
- Reset (async assert) values:
  - FSM = IDLE, counter = 0.
  - `mem_req`, `mem_we`, all `rvalid`, `done`, `dc_wready` = 0.
  - `owner` = 00; `mem_addr`, `mem_wdata`, `dc_beat` = 0.
  - The round-robin pointer points to I, so D is preferred after reset.
  - Asserting reset mid-burst aborts the burst with no `done`.
- Grant latency: `req` high in an IDLE cycle → `mem_req` high the next cycle.
- Burst length: minimum `LINE_WORDS` cycles with `mem_ack` every cycle. Each cycle with `mem_ack` low stalls one cycle, with address and data held.
- Exactly one IDLE bubble cycle between consecutive bursts.
- When `ic_req` and `dc_req` rise together, the loser waits one full burst plus one bubble cycle.

## Configuration
- `CACHE_ARB_RR_EN`: when defined, arbitration is round-robin.
  - A last-served pointer is updated on each grant.
  - On simultaneous requests, the side not served last wins.
- Without the macro: fixed priority, D always beats I on simultaneous requests. The pointer register is not built.

## Structure
- Shared package `cache_arb_pkg`: FSM state enum, `owner` encoding constants (OWN_NONE/OWN_I/OWN_D), beat-stride constant.
- One sub-module: `line_beat_counter`.
  - Parameter `LINE_WORDS`.
  - Inputs: `clr`, `inc`.
  - Outputs: `beat`, `last`.

## Test plan
- I-side refill with `ic_addr`=0x0000_1234, `mem_ack` every cycle:
  - `mem_addr` = 0x1220, 0x1224 … 0x123C.
  - 8 `ic_rvalid` pulses, `ic_done` on the 8th.
  - `owner` returns to 00.
- D-side writeback with `dc_addr`=0x2000 and `mem_ack` low on every other cycle:
  - 16 cycles total; `mem_we`=1 throughout.
  - `dc_beat` advances only on ack; `mem_wdata` follows `dc_beat`.
- `ic_req` and `dc_req` rise in the same cycle, repeated twice:
  - Fixed priority: D, D.
  - With `CACHE_ARB_RR_EN`: D, then I.
- `dc_req` dropped at beat 3: burst still runs 8 beats and `dc_done` pulses.
- `rst_n` pulled low at beat 5 of an I burst:
  - All outputs go to 0 immediately; no `ic_done`.
  - After release with `ic_req` held, the burst restarts at beat 0.
- Back-to-back requests with `ic_req` still high after `ic_done`: a second I burst starts after exactly one IDLE cycle.
